// File: rtl/seq_decoder_3to8.sv
`default_nettype none
// ============================================================================
// seq_decoder_3to8 : registered 3-to-8 decoder, valid/ready accept, timed
//                    one-hot strobes followed by a programmable idle gap.
// Revision         : 1.0
// ============================================================================
module seq_decoder_3to8 #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic valid,
  output logic ready,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic busy,
  output logic done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] code_q,  code_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] dec_q,   dec_d;
  logic       ready_q, ready_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          code_d  = {a, b, c};
          cnt_d   = HOLD_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 8'd0) begin
          if (GAP > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port is a plain flop.
  always_comb begin
    dec_d   = 8'd0;
    if (state_d == ST_DRIVE) begin
      dec_d = 8'd1 << code_d;
    end
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DRIVE) && (cnt_d == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
      dec_q   <= 8'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign d0    = dec_q[0];
  assign d1    = dec_q[1];
  assign d2    = dec_q[2];
  assign d3    = dec_q[3];
  assign d4    = dec_q[4];
  assign d5    = dec_q[5];
  assign d6    = dec_q[6];
  assign d7    = dec_q[7];

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder_3to8.sv
`default_nettype none
// ============================================================================
// tb_seq_decoder_3to8 : scoreboard bench for seq_decoder_3to8 (HOLD=4/GAP=1
//                       instance plus a HOLD=1/GAP=0 boundary instance).
// Revision            : 1.0
// ============================================================================
module tb_seq_decoder_3to8;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c;
  logic       valid_a, valid_b;
  logic       ready_a, busy_a, done_a;
  logic [7:0] d_a;
  logic       ready_b, busy_b, done_b;
  logic [7:0] d_b;

  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  logic [2:0] exp_q[$];
  int         acc_t[$];
  logic [8:0] expb_q[$];
  logic [7:0] mon_prev;
  int         mon_run;
  logic [2:0] mon_e;
  logic [8:0] eb;

  seq_decoder_3to8 #(.HOLD(HOLD_A), .GAP(GAP_A)) u_a (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .valid(valid_a),
    .ready(ready_a),
    .d0(d_a[0]), .d1(d_a[1]), .d2(d_a[2]), .d3(d_a[3]),
    .d4(d_a[4]), .d5(d_a[5]), .d6(d_a[6]), .d7(d_a[7]),
    .busy(busy_a), .done(done_a)
  );

  seq_decoder_3to8 #(.HOLD(1), .GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .valid(valid_b),
    .ready(ready_b),
    .d0(d_b[0]), .d1(d_b[1]), .d2(d_b[2]), .d3(d_b[3]),
    .d4(d_b[4]), .d5(d_b[5]), .d6(d_b[6]), .d7(d_b[7]),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present a code and wait (bounded) for the block to take it.
  task automatic send_a(input logic [2:0] code);
    int n;
    n = 0;
    {a, b, c} = code;
    valid_a   = 1'b1;
    while (ready_a !== 1'b1) begin
      @(negedge clk);
      n = n + 1;
      if (n > 50) begin
        check("accept_timeout", 32'(ready_a), 32'd1);
        return;
      end
    end
    exp_q.push_back(code);
    @(posedge clk);
    #1;
    acc_t.push_back(edge_cnt);
  endtask

  // Monitor: pops the scoreboard at each strobe start, checks length/done/one-hot.
  initial begin
    mon_prev = 8'd0;
    mon_run  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 8'd0;
        mon_run  = 0;
      end else begin
        check("onehot", 32'($countones(d_a) <= 1), 32'd1);
        if (d_a != 8'd0) begin
          if (d_a == mon_prev) begin
            mon_run = mon_run + 1;
          end else begin
            mon_run = 1;
            if (mon_prev != 8'd0) check("abutting_strobes", 32'(mon_prev), 32'd0);
            if (exp_q.size() == 0) begin
              check("unexpected_strobe", 32'(d_a), 32'd0);
            end else begin
              mon_e = exp_q.pop_front();
              check("strobe_code", 32'(d_a), 32'(8'd1 << mon_e));
            end
          end
          check("busy_in_drive", 32'(busy_a), 32'd1);
          check("ready_in_drive", 32'(ready_a), 32'd0);
        end else if (mon_prev != 8'd0) begin
          check("hold_len", 32'(mon_run), 32'(HOLD_A));
          mon_run = 0;
        end
        check("done", 32'(done_a), 32'((d_a != 8'd0) && (mon_run == HOLD_A)));
        mon_prev = d_a;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    valid_a = 1'b1;
    valid_b = 1'b0;
    {a, b, c} = 3'b101;

    // Reset held with a valid code pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_d", 32'(d_a), 32'd0);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
    end
    rst_n = 1'b1;
    exp_q.push_back(3'b101);
    @(posedge clk);
    #1;
    check("d5_after_release", 32'(d_a), 32'h20);
    valid_a = 1'b0;
    repeat (HOLD_A + GAP_A + 3) @(negedge clk);

    // Sweep all codes with valid held high.
    acc_t.delete();
    for (int i = 0; i < 8; i++) send_a(3'(i));
    valid_a = 1'b0;
    repeat (HOLD_A + GAP_A + 3) @(negedge clk);
    for (int i = 1; i < acc_t.size(); i++)
      check("sweep_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'(HOLD_A + GAP_A + 1));
    check("sweep_accepts", 32'(acc_t.size()), 32'd8);

    // Code change during DRIVE must wait for ready.
    acc_t.delete();
    send_a(3'b011);
    send_a(3'b110);
    valid_a = 1'b0;
    repeat (HOLD_A + GAP_A + 3) @(negedge clk);
    check("midpulse_spacing", 32'(acc_t[1] - acc_t[0]), 32'(HOLD_A + GAP_A + 1));

    // Boundary instance: HOLD=1, GAP=0, 111 then 000 back-to-back.
    @(negedge clk);
    {a, b, c} = 3'b111;
    valid_b   = 1'b1;
    check("b_ready", 32'(ready_b), 32'd1);
    @(posedge clk);
    #1;
    {a, b, c} = 3'b000;
    expb_q.push_back({1'b1, 8'h80});
    expb_q.push_back({1'b0, 8'h00});
    expb_q.push_back({1'b1, 8'h01});
    expb_q.push_back({1'b0, 8'h00});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      eb = expb_q.pop_front();
      check("b_strobe", 32'({done_b, d_b}), 32'(eb));
      if (k == 1) begin
        check("b_idle_ready", 32'(ready_b), 32'd1);
        @(posedge clk);
        #1;
        valid_b = 1'b0;
      end
    end

    // Asynchronous reset in the 2nd DRIVE cycle of code 010.
    send_a(3'b010);
    valid_a = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_d", 32'(d_a), 32'd0);
    check("abort_ready", 32'(ready_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    send_a(3'b100);
    valid_a = 1'b0;
    repeat (HOLD_A + GAP_A + 3) @(negedge clk);

    // Idle with toggling code and no valid.
    for (int k = 0; k < 10; k++) begin
      {a, b, c} = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("idle_d", 32'(d_a), 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_ready", 32'(ready_a), 32'd1);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
